// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - FIR result output FIFO with AXI-Stream master drain and frame FSM
//
// Purpose:
//   Captures one FIR result per w_fifo_en cycle into a DEPTH-entry show-ahead FIFO.
//   Each entry stores a last tag from done_fir, and that tag is presented as sm_tlast.
//   A three-state frame FSM (IDLE/ACTIVE/DRAIN) pulses frame_done when the frame leaves the FIFO.
//
// Optional feature:
//   FIR_OUT_LEN_CHECK_EN - counts output beats and sets sticky len_err when a frame is not
//   exactly FRAME_LEN beats long. When it is undefined, len_err is tied to 0.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   data_in, w_fifo_en     FIR sample and its write strobe
//   done_fir               last-sample marker, coincident with the final w_fifo_en
//   sm_tready              sink ready
//   sm_tvalid/tdata/tlast  head entry of the FIFO (show-ahead)
//   fifo_full, fifo_empty  level == DEPTH, level == 0
//   level                  entries held, 0..DEPTH
//   overflow               sticky: a write was dropped
//   frame_done             one-cycle pulse in the cycle the frame's final beat is accepted
//   len_err                sticky frame length mismatch (optional feature)

module fir_out_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              w_fifo_en,
  input  logic              done_fir,
  input  logic              sm_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              frame_done,
  output logic              len_err
);

  // Reject configurations where the pointers cannot wrap cleanly, or the frame is empty.
  if (DEPTH != (1 << ADDR_W) || FRAME_LEN < 1) begin : g_bad_cfg
    $error("fir_out_fifo: DEPTH must equal 2**ADDR_W and FRAME_LEN must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  state_e            state_q, state_d;

  logic              push;
  logic              pop;
  logic [DATA_W:0]   head;
  logic              drain_end;

  // Output view of the FIFO. Data is masked while empty, so stale storage never reaches the sink.
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == (ADDR_W+1)'(DEPTH));
  assign sm_tvalid  = !fifo_empty;
  assign sm_tdata   = sm_tvalid ? head[DATA_W-1:0] : '0;
  assign sm_tlast   = sm_tvalid & head[DATA_W];
  assign level      = level_q;
  assign overflow   = overflow_q;

  // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign pop  = sm_tvalid & sm_tready;
  assign push = w_fifo_en & (!fifo_full | pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q | (w_fifo_en & !push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset. Validity is carried entirely by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {done_fir, data_in};
    end
  end

  // The frame ends on the tagged beat. If the tag was dropped by an overflow, the frame
  // instead ends on the beat that leaves the FIFO empty.
  assign drain_end = pop & (sm_tlast | ((level_q == (ADDR_W+1)'(1)) & !push));

  // Frame FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM: next state. done_fir counts even when its sample is dropped, so a lost tag
  // still moves the FSM to DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_fifo_en && done_fir) begin
          state_d = ST_DRAIN;
        end else if (push) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_fifo_en && done_fir) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM: outputs.
  always_comb begin
    frame_done = (state_q == ST_DRAIN) && drain_end;
  end

`ifdef FIR_OUT_LEN_CHECK_EN
  localparam logic [31:0] LAST_IDX = 32'(FRAME_LEN - 1);

  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        len_err_q, len_err_d;

  // beat_cnt_q holds the number of beats already sent in the current frame. The beat that
  // arrives with beat_cnt_q == LAST_IDX must be the tagged one.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    if (pop) begin
      if (sm_tlast) begin
        if (beat_cnt_q != LAST_IDX) begin
          len_err_d = 1'b1;
        end
        beat_cnt_d = '0;
      end else begin
        if (beat_cnt_q == LAST_IDX) begin
          len_err_d = 1'b1;
        end
        beat_cnt_d = beat_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// tb/tb_fir_out_fifo.sv - directed self-checking bench for fir_out_fifo

module tb_fir_out_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        w_fifo_en;
  logic        done_fir;
  logic        sm_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  level;
  logic        overflow;
  logic        frame_done;
  logic        len_err;

  int checks = 0;
  int errors = 0;

`ifdef FIR_OUT_LEN_CHECK_EN
  localparam logic LEN_EXP = 1'b1;
`else
  localparam logic LEN_EXP = 1'b0;
`endif

  fir_out_fifo #(
    .DATA_W(32), .DEPTH(8), .ADDR_W(3), .FRAME_LEN(64)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .w_fifo_en(w_fifo_en),
    .done_fir(done_fir), .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
    .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .level(level), .overflow(overflow),
    .frame_done(frame_done), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes n untagged samples base+1..base+n with the sink stalled.
  task automatic fill(input int n, input logic [31:0] base);
    sm_tready = 1'b0;
    for (int i = 1; i <= n; i++) begin
      w_fifo_en = 1'b1;
      data_in   = base + 32'(i);
      done_fir  = 1'b0;
      tick();
    end
    w_fifo_en = 1'b0;
  endtask

  // Writes nwr samples base+1.. (done_fir on sample done_at) while draining. Expected beat k
  // carries base+k. tlast is expected on tlast_beat and frame_done on fd_beat. When toggle is
  // set, sm_tready alternates 0/1, and each stalled beat must hold its data and tlast.
  task automatic run(input int nwr, input logic [31:0] base, input int done_at,
                     input int tlast_beat, input int fd_beat, input bit toggle,
                     input int exp_beats, input string tag);
    int wi, beat, fd_cnt, tl_cnt;
    logic held, hl;
    logic [31:0] hd;
    wi = 0; beat = 0; fd_cnt = 0; tl_cnt = 0; held = 1'b0; hd = '0; hl = 1'b0;
    for (int c = 0; c < 200 && (wi < nwr || beat < exp_beats); c++) begin
      if (wi < nwr) begin
        wi++;
        w_fifo_en = 1'b1;
        data_in   = base + 32'(wi);
        done_fir  = (wi == done_at);
      end else begin
        w_fifo_en = 1'b0;
        done_fir  = 1'b0;
        data_in   = '0;
      end
      sm_tready = toggle ? c[0] : 1'b1;
      #1;
      if (held) begin
        chk({tag, " hold valid"}, sm_tvalid, 1'b1);
        chk({tag, " hold data"}, sm_tdata, hd);
        chk({tag, " hold last"}, sm_tlast, hl);
      end
      if (frame_done) fd_cnt++;
      if (sm_tvalid && sm_tready) begin
        beat++;
        chk({tag, " beat data"}, sm_tdata, base + 32'(beat));
        chk({tag, " beat last"}, sm_tlast, beat == tlast_beat);
        chk({tag, " beat frame_done"}, frame_done, beat == fd_beat);
        if (sm_tlast) tl_cnt++;
      end
      held = sm_tvalid && !sm_tready;
      hd   = sm_tdata;
      hl   = sm_tlast;
      @(posedge clk);
      #1;
    end
    w_fifo_en = 1'b0;
    done_fir  = 1'b0;
    sm_tready = 1'b0;
    chk({tag, " beat count"}, beat, exp_beats);
    chk({tag, " frame_done pulses"}, fd_cnt, 1);
    chk({tag, " tlast count"}, tl_cnt, (tlast_beat > 0) ? 1 : 0);
    chk({tag, " empty after"}, fifo_empty, 1'b1);
  endtask

  initial begin
    rst = 1'b1; data_in = '0; w_fifo_en = 1'b0; done_fir = 1'b0; sm_tready = 1'b0;
    #2;
    chk("reset level", level, 4'd0);
    chk("reset empty", fifo_empty, 1'b1);
    chk("reset full", fifo_full, 1'b0);
    chk("reset tvalid", sm_tvalid, 1'b0);
    chk("reset tdata", sm_tdata, 32'd0);
    chk("reset tlast", sm_tlast, 1'b0);
    chk("reset overflow", overflow, 1'b0);
    chk("reset frame_done", frame_done, 1'b0);
    chk("reset len_err", len_err, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Streaming: 64-sample frame with the sink always ready.
    run(64, 32'd0, 64, 64, 64, 1'b0, 64, "stream");
    chk("stream len_err", len_err, 1'b0);
    chk("stream overflow", overflow, 1'b0);

    // Backpressure: eight writes fill the FIFO, and a ninth tagged write is dropped.
    fill(8, 32'h100);
    chk("bp full", fifo_full, 1'b1);
    chk("bp level", level, 4'd8);
    chk("bp overflow pre", overflow, 1'b0);
    w_fifo_en = 1'b1; data_in = 32'h1FF; done_fir = 1'b1; sm_tready = 1'b0;
    tick();
    w_fifo_en = 1'b0; done_fir = 1'b0;
    chk("bp overflow set", overflow, 1'b1);
    chk("bp level hold", level, 4'd8);
    // The tag was lost, so frame_done must fire on the beat that empties the FIFO.
    run(0, 32'h100, 0, 0, 8, 1'b0, 8, "bp drain");
    chk("bp overflow sticky", overflow, 1'b1);
    chk("bp tvalid after", sm_tvalid, 1'b0);

    // Reset mid-stream with five entries held takes effect without a clock edge.
    fill(5, 32'h150);
    chk("mid level pre", level, 4'd5);
    rst = 1'b1;
    #1;
    chk("mid level", level, 4'd0);
    chk("mid empty", fifo_empty, 1'b1);
    chk("mid tvalid", sm_tvalid, 1'b0);
    chk("mid overflow", overflow, 1'b0);
    tick();
    rst = 1'b0;
    chk("mid empty after", fifo_empty, 1'b1);

    // Full FIFO with simultaneous push and pop.
    fill(8, 32'h200);
    chk("pp full", fifo_full, 1'b1);
    w_fifo_en = 1'b1; data_in = 32'h209; done_fir = 1'b1; sm_tready = 1'b1;
    #1;
    chk("pp head data", sm_tdata, 32'h201);
    chk("pp frame_done", frame_done, 1'b0);
    tick();
    w_fifo_en = 1'b0; done_fir = 1'b0; sm_tready = 1'b0;
    chk("pp level", level, 4'd8);
    chk("pp overflow", overflow, 1'b0);
    chk("pp full after", fifo_full, 1'b1);
    run(0, 32'h201, 0, 8, 8, 1'b0, 8, "pp drain");
    chk("pp len_err", len_err, LEN_EXP);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2 len_err", len_err, 1'b0);

    // Stall stability: a 10-sample frame with sm_tready toggling every cycle.
    run(10, 32'h300, 10, 10, 10, 1'b1, 10, "stall");
    chk("stall overflow", overflow, 1'b0);
    chk("stall len_err", len_err, LEN_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_fifo.md
Name: fir_out_fifo

Overview:
- Downstream stage of the FIR core: captures each FIR result on the write strobe and drains results to the DMA/stream sink over an AXI-Stream master port.
- The FIR core has no backpressure input. This FIFO absorbs sink stalls and marks frame boundaries:
  - done_fir is stored as a tag bit alongside the sample.
  - The tag becomes sm_tlast on the output.
- A small frame FSM reports frame completion to the controller.

Parameters:
- DATA_W, 32, sample width.
- DEPTH, 8, FIFO entries; must be a power of two.
- ADDR_W, 3, log2(DEPTH).
- FRAME_LEN, 64, expected samples per frame (used only by the optional check).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- data_in  in  DATA_W  FIR result (data_out of FIR core)
- w_fifo_en  in  1  write strobe, one sample per high cycle
- done_fir  in  1  last-sample marker; coincident with the final w_fifo_en
- sm_tready  in  1  sink ready
- sm_tvalid  out  1  head entry valid
- sm_tdata  out  DATA_W  head entry data
- sm_tlast  out  1  head entry is last of frame
- fifo_full  out  1  DEPTH entries held
- fifo_empty  out  1  zero entries held
- level  out  ADDR_W+1  entries held, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- frame_done  out  1  one-cycle pulse when the tlast beat is accepted
- len_err  out  1  sticky length mismatch (optional feature; 0 otherwise)

Behaviour:
- Reset (async, rst=1):
  - Pointers and level are 0; FSM goes to IDLE.
  - All outputs are 0 except fifo_empty=1.
  - Contents are discarded; a reset mid-frame loses all buffered samples, with no partial tlast emitted.
- Storage: DEPTH x (DATA_W+1) register array; bit DATA_W is the last tag.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH. level is tracked separately.
- Write:
  - push = w_fifo_en && (!fifo_full || pop).
  - Store {done_fir, data_in} at wr_ptr on the rising edge.
- Read:
  - pop = sm_tvalid && sm_tready; rd_ptr advances on the edge.
  - Show-ahead output: sm_tdata/sm_tlast come combinationally from entry[rd_ptr]; sm_tvalid = !fifo_empty.
- Latency: a sample written at edge N is visible on sm_tvalid/sm_tdata after edge N (1 cycle write-to-valid).
- Simultaneous push+pop:
  - level unchanged.
  - Legal when full: the slot freed by pop is reused in the same cycle.
  - Not possible when empty, since sm_tvalid=0.
- Overflow:
  - Triggered by w_fifo_en while full and no pop.
  - The sample is dropped and overflow is set; it stays set until rst.
  - If the dropped sample carried done_fir, the tag is lost. The FSM still moves to DRAIN, and frame_done fires when the FIFO empties.
- sm_tdata/sm_tlast must hold stable while sm_tvalid=1 and sm_tready=0.
- FSM (2-bit):
  - IDLE: first push -> ACTIVE.
  - ACTIVE: w_fifo_en with done_fir=1 -> DRAIN.
  - DRAIN:
    - Pop of a tlast entry -> IDLE with frame_done=1 that cycle.
    - Also -> IDLE with frame_done=1 when level reaches 0 with no tagged entry pending (overflow case).
  - Writes in DRAIN (next frame starting early) are accepted normally. The FSM returns through IDLE and then re-enters ACTIVE on the following push.
  - done_fir in IDLE with a push -> directly to DRAIN (single-sample frame).
- fifo_full = (level==DEPTH); fifo_empty = (level==0).

Optional Feature:
- FIR_OUT_LEN_CHECK_EN defined:
  - An output beat counter counts pops; it resets on tlast pop and on rst.
  - If a tlast beat is popped when count != FRAME_LEN-1, or count reaches FRAME_LEN-1 on a beat without tlast, len_err is set (sticky until rst).
- Not defined: no counter logic; len_err tied to 0.

Test Plan:
- Reset mid-stream: rst=1 with level=5 -> level=0, fifo_empty=1, sm_tvalid=0, overflow=0 immediately (async), no clock edge needed.
- Streaming: 64 writes with sm_tready=1, data 1..64, done_fir on #64 -> 64 beats in order, sm_tlast only on beat 64, frame_done exactly one pulse in the cycle beat 64 is accepted, len_err=0.
- Backpressure: sm_tready=0, write 8 samples -> fifo_full=1, level=8. 9th write is dropped and overflow=1. Release -> 8 beats, the 9th sample never appears.
- Full push+pop: full FIFO, sm_tready=1 and w_fifo_en in the same cycle -> level stays 8, overflow stays 0, new sample emerges after the 8 older ones.
- Stall stability: sm_tready toggled 0/1 every cycle during a frame -> sm_tdata/sm_tlast constant across each stalled cycle, no beat duplicated or skipped.
- With FIR_OUT_LEN_CHECK_EN: done_fir on the 10th sample -> len_err=1 after the 10th beat pops. Without the macro -> len_err=0.
